// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: load returns win the port, pipeline results
// queue in a small FIFO, and a one-entry load scoreboard keeps write-after-write order.
module wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_valid,
  output logic            pipe_ready,
  input  logic [4:0]      pipe_rd,
  input  logic [1:0]      pipe_sel,
  input  logic [XLEN-1:0] pipe_pc4,
  input  logic [XLEN-1:0] pipe_alu,
  input  logic            ld_issue,
  input  logic [4:0]      ld_rd,
  output logic            ld_ready,
  input  logic            dm_rvalid,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [1:0]      wb_sel,
  output logic [XLEN-1:0] wb_pc4,
  output logic [XLEN-1:0] wb_alu,
  output logic [XLEN-1:0] wb_dm
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [1:0]  SEL_FROM_ALU = 2'b00;
  localparam logic [1:0]  SEL_FROM_DM  = 2'b01;

  typedef struct packed {
    logic [4:0]      rd;
    logic [1:0]      sel;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] alu;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ld_pending_q, ld_pending_d;
  logic [4:0]       ld_pend_rd_q, ld_pend_rd_d;
  logic             ld_wr_en_q, ld_wr_en_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic [XLEN-1:0]  wb_pc4_q, wb_pc4_d, wb_alu_q, wb_alu_d, wb_dm_q, wb_dm_d;

  logic   push, pop, ld_commit;
  entry_t head;

  assign pipe_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign ld_ready   = !ld_pending_q && (count_q == '0);
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign wb_sel     = wb_sel_q;
  assign wb_pc4     = wb_pc4_q;
  assign wb_alu     = wb_alu_q;
  assign wb_dm      = wb_dm_q;

  // Next-state: FIFO bookkeeping, load scoreboard and commit selection
  always_comb begin
    push         = pipe_valid && pipe_ready;
    ld_commit    = dm_rvalid && ld_pending_q;
    pop          = !ld_commit && (count_q != '0);
    head         = mem_q[rd_ptr_q];
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    ld_pending_d = ld_pending_q;
    ld_pend_rd_d = ld_pend_rd_q;
    ld_wr_en_d   = ld_wr_en_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    wb_sel_d     = wb_sel_q;
    wb_pc4_d     = wb_pc4_q;
    wb_alu_d     = wb_alu_q;
    wb_dm_d      = wb_dm_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    // A younger pipeline write to the same register makes the load's write stale
    if (push && ld_pending_q && (pipe_rd == ld_pend_rd_q) && (pipe_rd != 5'd0))
      ld_wr_en_d = 1'b0;
    if (ld_commit) ld_pending_d = 1'b0;
    if (ld_issue) begin
      ld_pending_d = 1'b1;
      ld_pend_rd_d = ld_rd;
      ld_wr_en_d   = (ld_rd != 5'd0);
    end

    if (ld_commit) begin
      rf_we_d    = ld_wr_en_q;
      rf_waddr_d = ld_pend_rd_q;
      wb_sel_d   = SEL_FROM_DM;
      wb_dm_d    = dm_rdata;
    end else if (pop) begin
      rf_we_d    = (head.rd != 5'd0);
      rf_waddr_d = head.rd;
      wb_sel_d   = head.sel;
      wb_pc4_d   = head.pc4;
      wb_alu_d   = head.alu;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ld_pending_q <= 1'b0;
      ld_pend_rd_q <= 5'd0;
      ld_wr_en_q   <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      wb_sel_q     <= SEL_FROM_ALU;
      wb_pc4_q     <= '0;
      wb_alu_q     <= '0;
      wb_dm_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ld_pending_q <= ld_pending_d;
      ld_pend_rd_q <= ld_pend_rd_d;
      ld_wr_en_q   <= ld_wr_en_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      wb_sel_q     <= wb_sel_d;
      wb_pc4_q     <= wb_pc4_d;
      wb_alu_q     <= wb_alu_d;
      wb_dm_q      <= wb_dm_d;
    end
  end

  // Payload storage needs no reset; the count qualifies every slot
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: pipe_rd, sel: pipe_sel, pc4: pipe_pc4, alu: pipe_alu};
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes go into a queue
// in commit order and a negedge monitor pops one for every rf_we it observes.
module tb_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_DM  = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_valid, pipe_ready;
  logic [4:0]      pipe_rd;
  logic [1:0]      pipe_sel;
  logic [XLEN-1:0] pipe_pc4, pipe_alu;
  logic            ld_issue, ld_ready;
  logic [4:0]      ld_rd;
  logic            dm_rvalid;
  logic [XLEN-1:0] dm_rdata;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [1:0]      wb_sel;
  logic [XLEN-1:0] wb_pc4, wb_alu, wb_dm;

  wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_rd(pipe_rd),
    .pipe_sel(pipe_sel), .pipe_pc4(pipe_pc4), .pipe_alu(pipe_alu),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_ready(ld_ready),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .wb_sel(wb_sel),
    .wb_pc4(wb_pc4), .wb_alu(wb_alu), .wb_dm(wb_dm)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]      rd;
    logic [1:0]      sel;
    logic [XLEN-1:0] data;
    int              ecyc;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [1:0] sel,
                       input logic [XLEN-1:0] pc4, input logic [XLEN-1:0] alu);
    pipe_valid = 1'b1;
    pipe_rd    = rd;
    pipe_sel   = sel;
    pipe_pc4   = pc4;
    pipe_alu   = alu;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [1:0] sel,
                           input logic [XLEN-1:0] data, input int ecyc);
    q.push_back('{rd, sel, data, ecyc});
  endtask

  // Monitor: every observed write must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t            e;
    logic [XLEN-1:0] got;
    if (!rst && rf_we) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got waddr %0d at cycle %0d, required no write", rf_waddr, cyc);
      end else begin
        e = q.pop_front();
        case (e.sel)
          SEL_PC4: got = wb_pc4;
          SEL_DM:  got = wb_dm;
          default: got = wb_alu;
        endcase
        chk("mon_waddr", 64'(rf_waddr), 64'(e.rd));
        chk("mon_sel",   64'(wb_sel),   64'(e.sel));
        chk("mon_data",  64'(got),      64'(e.data));
        if (e.ecyc >= 0) chk("mon_latency", 64'(cyc), 64'(e.ecyc));
      end
    end
  end

  // Stimulus protocol guards
  always @(posedge clk) begin
    if (!rst && ld_issue && !ld_ready) begin
      n_total++;
      $display("FAIL illegal_issue: got ld_issue with ld_ready=0 at cycle %0d", cyc);
    end
    if (!rst && ld_issue && dm_rvalid) begin
      n_total++;
      $display("FAIL issue_with_return: got ld_issue and dm_rvalid together at cycle %0d", cyc);
    end
  end

  initial begin
    rst = 1'b1; pipe_valid = 1'b0; pipe_rd = '0; pipe_sel = '0; pipe_pc4 = '0; pipe_alu = '0;
    ld_issue = 1'b0; ld_rd = '0; dm_rvalid = 1'b0; dm_rdata = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_rf_we",      64'(rf_we),      64'(0));
    chk("rst_waddr",      64'(rf_waddr),   64'(0));
    chk("rst_wb_sel",     64'(wb_sel),     64'(SEL_ALU));
    chk("rst_wb_dm",      64'(wb_dm),      64'(0));
    chk("rst_pipe_ready", 64'(pipe_ready), 64'(1));
    chk("rst_ld_ready",   64'(ld_ready),   64'(1));

    // Back-to-back pipeline results, each written two cycles after its handshake
    offer(5'd1, SEL_ALU, 32'h0, 32'h11); expect_wr(5'd1, SEL_ALU, 32'h11, cyc + 2); step();
    chk("t1_pipe_ready", 64'(pipe_ready), 64'(1));
    offer(5'd2, SEL_ALU, 32'h0, 32'h22); expect_wr(5'd2, SEL_ALU, 32'h22, cyc + 2); step();
    offer(5'd3, SEL_ALU, 32'h0, 32'h33); expect_wr(5'd3, SEL_ALU, 32'h33, cyc + 2); step();
    pipe_valid = 1'b0;
    repeat (4) step();

    // Single load, returned three cycles after issue
    chk("t2_ld_ready_idle", 64'(ld_ready), 64'(1));
    ld_issue = 1'b1; ld_rd = 5'd5; step();
    ld_issue = 1'b0;
    chk("t2_ld_ready_busy", 64'(ld_ready), 64'(0));
    step(); step();
    chk("t2_ld_ready_wait", 64'(ld_ready), 64'(0));
    dm_rvalid = 1'b1; dm_rdata = 32'hDEADBEEF;
    expect_wr(5'd5, SEL_DM, 32'hDEADBEEF, cyc + 1);
    step();
    dm_rvalid = 1'b0;
    chk("t2_ld_ready_done", 64'(ld_ready), 64'(1));
    repeat (2) step();

    // Load return contends with queued results; FIFO fills and then drains in order
    expect_wr(5'd9,  SEL_DM,  32'h99, -1);
    expect_wr(5'd10, SEL_ALU, 32'hA0, -1);
    expect_wr(5'd11, SEL_ALU, 32'hB0, -1);
    expect_wr(5'd12, SEL_ALU, 32'hC0, -1);
    ld_issue = 1'b1; ld_rd = 5'd9; step();
    ld_issue = 1'b0;
    offer(5'd10, SEL_ALU, 32'h0, 32'hA0); step();
    offer(5'd11, SEL_ALU, 32'h0, 32'hB0);
    dm_rvalid = 1'b1; dm_rdata = 32'h99; step();
    dm_rvalid = 1'b0;
    chk("t3_pipe_ready_full", 64'(pipe_ready), 64'(0));
    offer(5'd12, SEL_ALU, 32'h0, 32'hC0); step();
    chk("t3_pipe_ready_free", 64'(pipe_ready), 64'(1));
    step();
    pipe_valid = 1'b0;
    repeat (4) step();
    chk("t3_ld_ready_end", 64'(ld_ready), 64'(1));

    // Younger pipeline write to the load's register cancels the load write
    ld_issue = 1'b1; ld_rd = 5'd7; step();
    ld_issue = 1'b0;
    offer(5'd7, SEL_PC4, 32'h104, 32'h55); expect_wr(5'd7, SEL_PC4, 32'h104, -1); step();
    pipe_valid = 1'b0;
    step(); step();
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFEF00D; step();
    dm_rvalid = 1'b0;
    chk("t4_cancel_we",  64'(rf_we),    64'(0));
    chk("t4_cancel_sel", 64'(wb_sel),   64'(SEL_DM));
    chk("t4_cancel_dm",  64'(wb_dm),    64'(32'hCAFEF00D));
    chk("t4_ld_ready",   64'(ld_ready), 64'(1));
    repeat (2) step();

    // Destination r0 never writes, from either source
    offer(5'd0, SEL_ALU, 32'h0, 32'h77); step();
    pipe_valid = 1'b0;
    chk("t5_pipe_ready", 64'(pipe_ready), 64'(1));
    step();
    chk("t5_pipe_r0_we",  64'(rf_we),  64'(0));
    chk("t5_pipe_r0_alu", 64'(wb_alu), 64'(32'h77));
    chk("t5_ld_ready",    64'(ld_ready), 64'(1));
    ld_issue = 1'b1; ld_rd = 5'd0; step();
    ld_issue = 1'b0;
    chk("t5_ld_ready_busy", 64'(ld_ready), 64'(0));
    dm_rvalid = 1'b1; dm_rdata = 32'h1234; step();
    dm_rvalid = 1'b0;
    chk("t5_ld_r0_we",      64'(rf_we),    64'(0));
    chk("t5_ld_r0_dm",      64'(wb_dm),    64'(32'h1234));
    chk("t5_ld_ready_done", 64'(ld_ready), 64'(1));
    step();

    // Reset with a buffered result and a load outstanding drops both
    ld_issue = 1'b1; ld_rd = 5'd3; offer(5'd4, SEL_ALU, 32'h0, 32'h44); step();
    ld_issue = 1'b0; pipe_valid = 1'b0;
    rst = 1'b1; #1;
    chk("t6_rst_we",         64'(rf_we),      64'(0));
    chk("t6_rst_waddr",      64'(rf_waddr),   64'(0));
    chk("t6_rst_sel",        64'(wb_sel),     64'(SEL_ALU));
    chk("t6_rst_pc4",        64'(wb_pc4),     64'(0));
    chk("t6_rst_alu",        64'(wb_alu),     64'(0));
    chk("t6_rst_dm",         64'(wb_dm),      64'(0));
    chk("t6_rst_pipe_ready", 64'(pipe_ready), 64'(1));
    chk("t6_rst_ld_ready",   64'(ld_ready),   64'(1));
    step(); step();
    rst = 1'b0;
    step();
    dm_rvalid = 1'b1; dm_rdata = 32'hBAD; step();
    dm_rvalid = 1'b0;
    chk("t6_late_rvalid_we", 64'(rf_we),    64'(0));
    chk("t6_late_rvalid_dm", 64'(wb_dm),    64'(0));
    chk("t6_ld_ready",       64'(ld_ready), 64'(1));
    repeat (5) step();

    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
